// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator.
// Sends a PAT_W-bit pattern MSB first, repeated count times, with no gaps
// between bits or between repetitions. All outputs are registered.
//
// Ports
//   clk      in   system clock; state changes on the rising edge
//   clr_n    in   asynchronous active-low clear
//   start    in   transfer request, sampled only in IDLE
//   pattern  in   [PAT_W-1:0] bits to send, latched on an accepted start
//   count    in   [CNT_W-1:0] number of repetitions, latched on an accepted start
//   abort    in   synchronous cancel of the transfer in progress
//   d        out  serial data (IDLE_LVL when no bit is being sent)
//   valid    out  d carries a pattern bit this cycle
//   busy     out  transfer in progress
//   done     out  one-cycle pulse after the last bit of a completed transfer
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; outputs at idle values
// S_SHIFT | one pattern bit on d per cycle
// S_DONE  | single-cycle done pulse, then back to S_IDLE

module seq_gen #(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             d,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  // Repetitions remaining, including the one currently on the wire. Holding
  // "remaining" rather than "done so far" lets the full CNT_W range be used.
  logic [CNT_W-1:0] rep_q, rep_d;
  // Index of the bit currently being sent.
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             d_q, d_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      d_q     <= IDLE_LVL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are computed for the cycle after the edge, so every output
  // register holds what the next state presents.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    d_d     = IDLE_LVL;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          pat_d = pattern;
          rep_d = count;
          idx_d = IDX_MAX;
          if (count != '0) begin
            state_d = S_SHIFT;
            d_d     = pattern[PAT_W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q == '0) begin
          if (rep_q == REP_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            rep_d   = rep_q - 1'b1;
            idx_d   = IDX_MAX;
            d_d     = pat_q[PAT_W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end else begin
          idx_d   = idx_q - 1'b1;
          d_d     = pat_q[idx_q - 1'b1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign d     = d_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed self-checking bench for seq_gen (PAT_W=4, CNT_W=4).
// Inputs change 1 time unit after the rising edge, outputs are sampled there.

module tb_seq_gen;

  logic       clk;
  logic       clr_n;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] count;
  logic       abort;
  logic       d;
  logic       valid;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  seq_gen #(
    .PAT_W   (4),
    .CNT_W   (4),
    .IDLE_LVL(1'b0)
  ) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (start),
    .pattern(pattern),
    .count  (count),
    .abort  (abort),
    .d      (d),
    .valid  (valid),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for start_len edges (then scrambles pattern/count), and
  // observes ncyc cycles after those edges.
  task automatic capture(input logic [3:0] pat, input logic [3:0] cnt,
                         input int start_len, input int ncyc,
                         output int nvalid, output logic [63:0] seq,
                         output int ndone, output int done_at,
                         output int nstarts, output int nbusy, output int ndet);
    logic       prev_v;
    logic [3:0] win;
    nvalid = 0; seq = '0; ndone = 0; done_at = 0;
    nstarts = 0; nbusy = 0; ndet = 0;
    prev_v = 1'b0; win = '0;
    pattern = pat;
    count   = cnt;
    for (int i = 0; i < ncyc; i++) begin
      start = (i < start_len);
      if (i == start_len) begin
        pattern = ~pat;
        count   = cnt + 4'd1;
      end
      step();
      if (valid) begin
        nvalid++;
        seq = {seq[62:0], d};
        win = {win[2:0], d};
        if (win == 4'b1010) ndet++;
        if (!prev_v) nstarts++;
      end
      prev_v = valid;
      if (done) begin
        ndone++;
        if (done_at == 0) done_at = i + 1;
      end
      if (busy) nbusy++;
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nv, nd, da, ns, nb, ndt;
    logic [63:0] sq;
    logic [3:0]  exp_bits;

    clr_n   = 1'b0;
    start   = 1'b1;
    pattern = 4'b1010;
    count   = 4'd1;
    abort   = 1'b0;

    // Reset state, with start already present
    step();
    chk("rst_d", d, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Release away from an edge; first edge must accept the pending start
    #2 clr_n = 1'b1;
    step();
    start = 1'b0;
    exp_bits = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("single_d%0d", i), d, exp_bits[3-i]);
      chk($sformatf("single_valid%0d", i), valid, 1);
      chk($sformatf("single_busy%0d", i), busy, 1);
      chk($sformatf("single_done%0d", i), done, 0);
      step();
    end
    chk("single_done_pulse", done, 1);
    chk("single_done_valid", valid, 0);
    chk("single_done_busy", busy, 0);
    chk("single_done_d", d, 0);
    step();
    chk("single_done_end", done, 0);

    // Three repetitions of 1010, pattern/count scrambled after start
    capture(4'b1010, 4'd3, 1, 16, nv, sq, nd, da, ns, nb, ndt);
    chk("rep3_nvalid", nv, 12);
    chk("rep3_seq", sq, 64'hAAA);
    chk("rep3_ndone", nd, 1);
    chk("rep3_done_at", da, 13);
    chk("rep3_contig", ns, 1);
    chk("rep3_nbusy", nb, 12);
    chk("rep3_det1010", ndt, 5);

    // count == 0
    capture(4'b1111, 4'd0, 1, 6, nv, sq, nd, da, ns, nb, ndt);
    chk("cnt0_nvalid", nv, 0);
    chk("cnt0_ndone", nd, 1);
    chk("cnt0_done_at", da, 1);
    chk("cnt0_nbusy", nb, 0);

    // Abort on bit 5 of 1100 x2
    pattern = 4'b1100;
    count   = 4'd2;
    start   = 1'b1;
    step();
    start   = 1'b0;
    pattern = 4'b0000;
    chk("abort_b1", d, 1);
    step();
    step();
    step();
    chk("abort_b4_d", d, 0);
    chk("abort_b4_valid", valid, 1);
    step();
    chk("abort_b5_d", d, 1);
    chk("abort_b5_valid", valid, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_d", d, 0);
    capture(4'b1100, 4'd2, 0, 6, nv, sq, nd, da, ns, nb, ndt);
    chk("abort_quiet_nvalid", nv, 0);
    chk("abort_quiet_ndone", nd, 0);
    capture(4'b0110, 4'd1, 1, 8, nv, sq, nd, da, ns, nb, ndt);
    chk("post_abort_nvalid", nv, 4);
    chk("post_abort_seq", sq, 64'h6);
    chk("post_abort_done_at", da, 5);

    // start held for 10 edges: transfers accepted at edges 0 and 6
    capture(4'b1010, 4'd1, 10, 20, nv, sq, nd, da, ns, nb, ndt);
    chk("hold_nvalid", nv, 8);
    chk("hold_seq", sq, 64'hAA);
    chk("hold_ndone", nd, 2);
    chk("hold_done_at", da, 5);
    chk("hold_nstarts", ns, 2);

    // abort together with start in IDLE
    pattern = 4'b1111;
    count   = 4'd1;
    start   = 1'b1;
    abort   = 1'b1;
    step();
    start   = 1'b0;
    abort   = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_valid", valid, 0);
    capture(4'b1111, 4'd1, 0, 5, nv, sq, nd, da, ns, nb, ndt);
    chk("abort_start_nvalid", nv, 0);
    chk("abort_start_ndone", nd, 0);

    // Maximum count: 15 repetitions
    capture(4'b1001, 4'd15, 1, 64, nv, sq, nd, da, ns, nb, ndt);
    chk("max_nvalid", nv, 60);
    chk("max_seq", sq, 64'h0999999999999999);
    chk("max_ndone", nd, 1);
    chk("max_done_at", da, 61);
    chk("max_nstarts", ns, 1);

    // Asynchronous clear during bit 2 of 1100 x2
    pattern = 4'b1100;
    count   = 4'd2;
    start   = 1'b1;
    step();
    start   = 1'b0;
    step();
    chk("clr_pre_valid", valid, 1);
    chk("clr_pre_d", d, 1);
    #2 clr_n = 1'b0;
    #1;
    chk("clr_async_d", d, 0);
    chk("clr_async_valid", valid, 0);
    chk("clr_async_busy", busy, 0);
    chk("clr_async_done", done, 0);
    #1 clr_n = 1'b1;
    capture(4'b1100, 4'd2, 0, 12, nv, sq, nd, da, ns, nb, ndt);
    chk("clr_quiet_nvalid", nv, 0);
    chk("clr_quiet_ndone", nd, 0);
    chk("clr_quiet_nbusy", nb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
